// File: rtl/mac_serial_acc.sv
// Serial shift-add multiply-accumulate: one operand pair per in_valid, sum on a one-cycle out_valid.
// Optional MAC_SAT_EN: accumulator clamps at 2^OUT_W-1 instead of wrapping.
module mac_serial_acc #(
   parameter int DATA_W = 4,
   parameter int OUT_W  = 10
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] in1_IFM,
   input  logic [DATA_W-1:0] in2_IFM,
   output logic              out_valid,
   output logic [OUT_W-1:0]  Out_OFM
);

   localparam int PROD_W = 2 * DATA_W;
   localparam int STEP_W = $clog2(DATA_W + 1);

   typedef enum logic [1:0] {
      IDLE,
      MUL,
      ACC
   } state_t;

   state_t            r_state;
   state_t            w_nextState;
   logic [PROD_W-1:0] r_mcand;
   logic [PROD_W-1:0] r_prod;
   logic [DATA_W-1:0] r_mplier;
   logic [STEP_W-1:0] r_step;
   logic [OUT_W-1:0]  r_acc;
   logic              r_outValid;
   logic [OUT_W:0]    w_sum;
   logic [OUT_W-1:0]  w_accNext;
   logic              w_lastStep;

   assign w_lastStep = (r_step == STEP_W'(DATA_W - 1));
   assign out_valid  = r_outValid;
   assign Out_OFM    = r_acc;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   always_comb begin
      w_nextState = r_state;
      case (r_state)
         IDLE:    if (in_valid) w_nextState = MUL;
         MUL:     if (w_lastStep) w_nextState = ACC;
         ACC:     w_nextState = IDLE;
         default: w_nextState = IDLE;
      endcase
   end

   // The extra carry bit of w_sum is what detects overflow for saturation.
   always_comb begin
      w_sum = {1'b0, r_acc} + (OUT_W + 1)'(r_prod);
`ifdef MAC_SAT_EN
      w_accNext = w_sum[OUT_W] ? {OUT_W{1'b1}} : w_sum[OUT_W-1:0];
`else
      w_accNext = w_sum[OUT_W-1:0];
`endif
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_mcand    <= '0;
         r_prod     <= '0;
         r_mplier   <= '0;
         r_step     <= '0;
         r_acc      <= '0;
         r_outValid <= 1'b0;
      end else begin
         r_outValid <= 1'b0;
         case (r_state)
            IDLE: begin
               if (in_valid) begin
                  r_mcand  <= PROD_W'(in1_IFM);
                  r_mplier <= in2_IFM;
                  r_prod   <= '0;
                  r_step   <= '0;
               end
            end
            MUL: begin
               if (r_mplier[0]) r_prod <= r_prod + r_mcand;
               r_mcand  <= r_mcand << 1;
               r_mplier <= r_mplier >> 1;
               r_step   <= r_step + 1'b1;
            end
            ACC: begin
               r_acc      <= w_accNext;
               r_outValid <= 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule
